// File: rtl/cabac_pkg.sv
// Shared types and constants for the CABAC regular-bin engine.
// State encoding and arithmetic-decoder register initial values.
package cabac_pkg;

  localparam int CABAC_VALUE_W = 16;
  localparam int CABAC_RANGE_W = 9;

  localparam logic [CABAC_RANGE_W-1:0] CABAC_RANGE_INIT = 9'd510;
  localparam logic signed [3:0] CABAC_BITS_NEEDED_INIT = -4'sd8;

  typedef enum logic [2:0] {
    IDLE,
    INIT0,
    INIT1,
    READY,
    REFILL
  } cabac_state_e;

endpackage

// File: rtl/cabac_engine_state.sv
// Arithmetic-decoder state registers and byte refill for the
// CABAC regular-bin path; decode math lives in a separate stage.
module cabac_engine_state
  import cabac_pkg::*;
#(
  parameter int BIN_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_in,
  output logic                 byte_ready,
  input  logic                 req_valid,
  input  logic [7:0]           req_pstate,
  output logic                 req_ready,
  output logic                 bin_valid,
  output logic [BIN_WIDTH-1:0] bin_data,
  output logic [8:0]           dec_range,
  output logic [15:0]          dec_value,
  output logic [7:0]           dec_pstate,
  input  logic [8:0]           dec_range_next,
  input  logic [15:0]          dec_value_next,
  input  logic [2:0]           dec_num_bits,
  input  logic [BIN_WIDTH-1:0] dec_bin
);

  cabac_state_e state;

  logic [CABAC_RANGE_W-1:0] m_range;
  logic [CABAC_VALUE_W-1:0] m_value;
  logic [3:0]               bits_needed;

  logic        byte_fire;
  logic        req_fire;
  logic [4:0]  bn;
  logic [15:0] refill_add;

  assign byte_ready = (state == INIT0) ||
                      (state == INIT1) ||
                      (state == REFILL);

  assign req_ready = (state == READY) && !start;

  assign byte_fire = byte_valid && byte_ready;
  assign req_fire  = req_valid && req_ready;

  assign dec_range  = m_range;
  assign dec_value  = m_value;
  assign dec_pstate = req_pstate;

  // Sign-extend to 5 bits so the sign of the sum is bit 4.
  assign bn = {bits_needed[3], bits_needed} +
              {2'b00, dec_num_bits};

  // Only used in REFILL, where bits_needed is 0..5.
  assign refill_add = {8'h00, byte_in} << bits_needed[2:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      m_range     <= '0;
      m_value     <= '0;
      bits_needed <= '0;
      bin_valid   <= 1'b0;
      bin_data    <= '0;
    end else begin
      bin_valid <= 1'b0;
      if (start) begin
        state <= INIT0;
      end else begin
        unique case (state)
          IDLE: begin
          end
          INIT0: begin
            if (byte_fire) begin
              m_value[15:8] <= byte_in;
              state         <= INIT1;
            end
          end
          INIT1: begin
            if (byte_fire) begin
              m_value[7:0] <= byte_in;
              m_range      <= CABAC_RANGE_INIT;
              bits_needed  <= CABAC_BITS_NEEDED_INIT;
              state        <= READY;
            end
          end
          READY: begin
            if (req_fire) begin
              m_range     <= dec_range_next;
              m_value     <= dec_value_next;
              bin_data    <= dec_bin;
              bin_valid   <= 1'b1;
              bits_needed <= bn[3:0];
              if (!bn[4]) state <= REFILL;
            end
          end
          REFILL: begin
            if (byte_fire) begin
              m_value     <= m_value + refill_add;
              bits_needed <= bits_needed - 4'd8;
              state       <= READY;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/cabac_engine_state.md
# cabac_engine_state

Sequential state holder and bitstream refill unit for the CABAC regular-bin path. It owns the arithmetic-decoder registers `m_range`, `m_value` and `bits_needed`, and drives them into the combinational regular-bin decode stage. It consumes that stage's next-state results and tops up `m_value` one byte at a time from an upstream byte source. It sits between the slice-data byte fetcher upstream and the syntax-element parser downstream, which issues bin requests and receives decoded bins.

## Interface
- `BIN_WIDTH`, default 4: width of the bin value returned by the decode stage.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high; the only reset.
- `start` in 1: one-cycle pulse; (re)initialise the engine for a new slice.
- `byte_valid` in 1: upstream byte available.
- `byte_in` in 8: bitstream byte.
- `byte_ready` out 1: block accepts `byte_in` this cycle; a transfer occurs when `byte_valid && byte_ready`.
- `req_valid` in 1: parser requests one regular bin.
- `req_pstate` in 8: probability state for the request.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `bin_valid` out 1: one-cycle pulse; `bin_data` valid. No backpressure.
- `bin_data` out BIN_WIDTH: decoded bin.
- `dec_range` out 9: current `m_range` to the decode stage.
- `dec_value` out 16: current `m_value` to the decode stage.
- `dec_pstate` out 8: equals `req_pstate` (combinational pass-through).
- `dec_range_next` in 9: decode-stage `m_range_out`.
- `dec_value_next` in 16: decode-stage `m_value_out`, already shifted by `numBits`.
- `dec_num_bits` in 3: renormalisation shift, 0..6.
- `dec_bin` in BIN_WIDTH: decode-stage `bin_out`.

## Operation
- FSM states: IDLE, INIT0, INIT1, READY, REFILL.
- IDLE: `byte_ready`=0, `req_ready`=0. On `start`, go to INIT0.
- INIT0: `byte_ready`=1. On transfer: `m_value[15:8]`=byte, go to INIT1.
- INIT1: `byte_ready`=1. On transfer: `m_value[7:0]`=byte, `m_range`=510, `bits_needed`=-8, go to READY.
- READY: `req_ready`=1, `byte_ready`=0. On request accept:
  - `m_range` ← `dec_range_next`.
  - `m_value` ← `dec_value_next`.
  - `bin_data` ← `dec_bin`; `bin_valid` pulses next cycle.
  - `bn` = `bits_needed` + `dec_num_bits`.
  - If `bn` < 0: `bits_needed` ← `bn`, stay in READY.
  - Otherwise: `bits_needed` ← `bn`, go to REFILL.
- REFILL: `byte_ready`=1, `req_ready`=0. On transfer: `m_value` ← `m_value` + (byte << `bits_needed`), `bits_needed` ← `bits_needed` - 8, go to READY.
  - Stall indefinitely while `byte_valid`=0; all registers hold.
- `bits_needed`: 4-bit two's complement, range -8..+5.
- Value add: 16-bit, with the shifted byte zero-extended (byte << 5 still fits). Wrap-around is not possible by the CABAC invariant `m_value` < `m_range`<<7; the bench asserts this invariant.
- `start` in any non-IDLE state restarts at INIT0. A pending refill is discarded; `bin_valid` is not generated for it.
- `start` coincident with a request accept: `start` wins, the request is not accepted (`req_ready` is forced 0 that cycle).
- `rst` mid-operation: all state returns to reset values on the next edge; any in-flight byte is dropped.

## Timing
- Reset values:
  - state = IDLE.
  - `m_range`=0, `m_value`=0, `bits_needed`=0.
  - `bin_valid`=0, `bin_data`=0.
  - `byte_ready`=0, `req_ready`=0.
- Bin latency: `bin_valid` is asserted exactly 1 cycle after request acceptance.
- Back-to-back rate: one bin per cycle while no refill is needed. Each refill inserts at least 1 bubble cycle; the next request can be accepted the cycle after the byte transfer.
- Init: 2 byte transfers after `start`. `req_ready` rises the cycle after the second transfer.
- `byte_ready` and `req_ready` are decoded from registered state only, with no combinational path from `byte_valid` or `req_valid`. `req_ready` is additionally gated by `start`.
- `dec_*` outputs are registered state (except `dec_pstate`). The decode-stage round trip is one combinational cycle.

## Structure
- Shared package `cabac_pkg`:
  - State enum.
  - `CABAC_RANGE_INIT` = 510.
  - `CABAC_BITS_NEEDED_INIT` = -8.
  - `CABAC_VALUE_W` = 16, `CABAC_RANGE_W` = 9.
- No sub-module required. A top wrapper (`cabac_regular_engine`, separate block) instantiates this block plus the decode stage.

## Test plan
- Init: `start`, then bytes 0x12, 0x34 → `m_value`=0x1234, `m_range`=0x1FE, `bits_needed`=-8, `req_ready`=1 next cycle.
- No refill, with stubbed `dec_num_bits`=0, `dec_bin`=1 → `bin_valid` pulses with `bin_data`=1 one cycle after accept, `bits_needed` stays -8, `req_ready` stays 1. Four back-to-back requests → four consecutive `bin_valid` pulses.
- Refill, starting from `bits_needed`=-8:
  - Request with `num_bits`=6 → `bits_needed`=-2, no refill.
  - Request with `num_bits`=3 → `bits_needed`=1, REFILL.
  - Byte 0xA5 → `m_value` += 0x14A, `bits_needed`=-7.
- Refill stall: in REFILL, hold `byte_valid`=0 for 5 cycles → `req_ready`=0 and registers unchanged. Byte arrives → READY the next cycle.
- `start` during REFILL → state INIT0, no `bin_valid`, `m_value` reloaded from the next two bytes.
- `rst` asserted mid-init, after 1 byte → all outputs at reset values next cycle; a full re-init with a new `start` succeeds.
